// File: rtl/qc_shift_mem_sequencer.sv
// Address/control sequencer for the async-read, sync-write message RAM: linear LOAD,
// and READ / WRITEBACK sweeps that visit word (s + n) mod MEMDEPTH on step n.
module qc_shift_mem_sequencer #(
  parameter int W            = 6,
  parameter int ADDRESSWIDTH = 9,
  parameter int MEMDEPTH     = 16
) (
  input  logic                    memclk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_op,
  input  logic [ADDRESSWIDTH-1:0] cmd_shift,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [W-1:0]            in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [W-1:0]            out_data,
  output logic [ADDRESSWIDTH-1:0] mem_ra,
  output logic                    mem_rd,
  input  logic [W-1:0]            mem_dout,
  output logic [ADDRESSWIDTH-1:0] mem_wa,
  output logic                    mem_wr,
  output logic [W-1:0]            mem_din,
  output logic                    done,
  output logic                    cmd_err,
  output logic                    busy
);

  localparam int                      CW        = $clog2(MEMDEPTH + 1);
  localparam logic [ADDRESSWIDTH-1:0] LAST_PTR  = ADDRESSWIDTH'(MEMDEPTH - 1);
  localparam logic [ADDRESSWIDTH-1:0] ONE_PTR   = ADDRESSWIDTH'(1);
  localparam logic [ADDRESSWIDTH:0]   DEPTH_EXT = (ADDRESSWIDTH + 1)'(MEMDEPTH);
  localparam logic [CW-1:0]           DEPTH_CNT = CW'(MEMDEPTH);
  localparam logic [CW-1:0]           LAST_CNT  = CW'(MEMDEPTH - 1);
  localparam logic [CW-1:0]           ONE_CNT   = CW'(1);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_READ = 2'b01;
  localparam logic [1:0] OP_WB   = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_READ, S_WB} state_t;

  state_t                  r_state, w_next_state;
  logic [ADDRESSWIDTH-1:0] r_ptr;
  logic [ADDRESSWIDTH-1:0] w_ptr_inc;
  logic [CW-1:0]           r_cnt;
  logic [W-1:0]            r_out_data;
  logic                    r_out_valid, r_done, r_cmd_err;
  logic                    w_cmd_bad, w_cmd_take, w_wr_xfer, w_rd_issue, w_out_hs, w_sweep_end;

  assign w_cmd_bad  = (cmd_op == OP_RSVD) ||
                      ((cmd_op != OP_LOAD) && ({1'b0, cmd_shift} >= DEPTH_EXT));
  assign w_cmd_take = (r_state == S_IDLE) && cmd_valid && !w_cmd_bad;
  assign w_wr_xfer  = ((r_state == S_LOAD) || (r_state == S_WB)) && in_valid;
  // A read may issue only when the single output register is empty or draining this cycle.
  assign w_rd_issue = (r_state == S_READ) && (r_cnt < DEPTH_CNT) && (!r_out_valid || out_ready);
  assign w_out_hs   = r_out_valid && out_ready;
  // Once every read is issued, the word left in the output register is the last one.
  assign w_sweep_end = (w_wr_xfer && (r_cnt == LAST_CNT)) ||
                       ((r_state == S_READ) && w_out_hs && (r_cnt == DEPTH_CNT));
  assign w_ptr_inc  = (r_ptr == LAST_PTR) ? '0 : r_ptr + ONE_PTR;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge memclk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next_state;
  end

  // NOTE: each combinational block assigns a default first so no path leaves an
  // output unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_cmd_take) begin
          case (cmd_op)
            OP_LOAD: w_next_state = S_LOAD;
            OP_READ: w_next_state = S_READ;
            default: w_next_state = S_WB;
          endcase
        end
      end
      S_LOAD, S_READ, S_WB: if (w_sweep_end) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (r_state == S_IDLE);
    busy      = (r_state != S_IDLE);
    in_ready  = (r_state == S_LOAD) || (r_state == S_WB);
    mem_wr    = w_wr_xfer;
    mem_wa    = r_ptr;
    mem_din   = in_data;
    mem_rd    = w_rd_issue;
    mem_ra    = w_rd_issue ? r_ptr : '0;
    out_valid = r_out_valid;
    out_data  = r_out_data;
    done      = r_done;
    cmd_err   = r_cmd_err;
  end

  always_ff @(posedge memclk) begin
    if (!rst) begin
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
      r_cmd_err   <= 1'b0;
    end else begin
      r_done    <= w_sweep_end;
      r_cmd_err <= (r_state == S_IDLE) && cmd_valid && w_cmd_bad;
      if (w_cmd_take) begin
        r_ptr <= (cmd_op == OP_LOAD) ? '0 : cmd_shift;
        r_cnt <= '0;
      end else if (w_wr_xfer || w_rd_issue) begin
        r_ptr <= w_ptr_inc;
        r_cnt <= r_cnt + ONE_CNT;
      end
      if (w_rd_issue) begin
        r_out_data  <= mem_dout;
        r_out_valid <= 1'b1;
      end else if (w_out_hs) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule
